// File: rtl/axi_pkg.sv
// Shared AXI definitions for the m00_axi read/write masters: the read-side
// state encoding and the fixed AXI field encodings used on the AR channel.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_ADDR = 2'd1,
        GET_DATA  = 2'd2,
        DONE      = 2'd3
    } ReadState_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_read_master.sv
// Single-ID AXI4 read master: fetches read_data_len_in consecutive 32-bit
// words starting at read_addr_in, one single-beat AXI transaction per word,
// and streams each word out with a one-cycle read_valid_out strobe.
// Optional feature macro: AXI_READ_RESP_CHECK_EN enables a sticky
// read_err_out flag for non-OKAY read responses; otherwise it is tied to 0.
module axi_read_master
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_INC = 32'd4,
    parameter logic [5:0]  AR_ID    = 6'd0
) (
    input  logic        m00_axi_aclk,
    input  logic        m00_axi_aresetn,

    input  logic        read_en_in,
    input  logic [31:0] read_addr_in,
    input  logic [31:0] read_data_len_in,
    output logic [31:0] read_data_out,
    output logic        read_valid_out,
    output logic        read_done_out,
    output logic        read_err_out,

    output logic [5:0]  m00_axi_arid,
    output logic [31:0] m00_axi_araddr,
    output logic [3:0]  m00_axi_arlen,
    output logic [2:0]  m00_axi_arsize,
    output logic [1:0]  m00_axi_arburst,
    output logic        m00_axi_arlock,
    output logic [3:0]  m00_axi_arcache,
    output logic [2:0]  m00_axi_arprot,
    output logic [3:0]  m00_axi_arqos,
    output logic        m00_axi_arvalid,
    input  logic        m00_axi_arready,

    input  logic [5:0]  m00_axi_rid,
    input  logic [31:0] m00_axi_rdata,
    input  logic [1:0]  m00_axi_rresp,
    input  logic        m00_axi_rlast,
    input  logic        m00_axi_rvalid,
    output logic        m00_axi_rready
);

    ReadState_t  state;
    ReadState_t  next_state;
    logic [31:0] curr_addr;
    logic [31:0] remaining;
    logic        start;
    logic        beat;

    // rid and rlast are deliberately not checked: every accepted beat ends
    // its single-beat transaction.
    logic        unused_r_fields;
    assign unused_r_fields = ^{m00_axi_rid, m00_axi_rlast};

    assign start = (state == IDLE) && read_en_in;
    assign beat  = (state == GET_DATA) && m00_axi_rvalid;

    // State register.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one AR then one R beat per word, DONE for one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (read_en_in) begin
                    next_state = (read_data_len_in == 32'd0) ? DONE : SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                if (m00_axi_arready) begin
                    next_state = GET_DATA;
                end
            end
            GET_DATA: begin
                if (m00_axi_rvalid) begin
                    next_state = (remaining == 32'd0) ? DONE : SEND_ADDR;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // AR/R handshake controls are decoded straight from the state so the
    // address stays on the bus, unchanged, until arready is seen.
    always_comb begin
        m00_axi_arvalid = (state == SEND_ADDR);
        m00_axi_araddr  = (state == SEND_ADDR) ? curr_addr : 32'd0;
        m00_axi_rready  = (state == GET_DATA);
        read_done_out   = (state == DONE);
    end

    assign m00_axi_arid    = AR_ID;
    assign m00_axi_arlen   = 4'd0;
    assign m00_axi_arsize  = AXI_SIZE_4B;
    assign m00_axi_arburst = AXI_BURST_INCR;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = 4'd0;
    assign m00_axi_arprot  = 3'd0;
    assign m00_axi_arqos   = 4'd0;

    // Address/word counter and captured read data; the counter holds
    // "words left after the current one", so zero marks the last beat.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            curr_addr      <= 32'd0;
            remaining      <= 32'd0;
            read_data_out  <= 32'd0;
            read_valid_out <= 1'b0;
        end else begin
            read_valid_out <= beat;
            if (start) begin
                curr_addr <= read_addr_in;
                remaining <= read_data_len_in - 32'd1;
            end else if (beat) begin
                read_data_out <= m00_axi_rdata;
                if (remaining != 32'd0) begin
                    remaining <= remaining - 32'd1;
                    curr_addr <= curr_addr + ADDR_INC;
                end
            end
        end
    end

`ifdef AXI_READ_RESP_CHECK_EN
    // Sticky response error: cleared by an accepted start, set by any
    // accepted beat whose response is not OKAY.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            read_err_out <= 1'b0;
        end else if (start) begin
            read_err_out <= 1'b0;
        end else if (beat && (m00_axi_rresp != AXI_RESP_OKAY)) begin
            read_err_out <= 1'b1;
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^m00_axi_rresp;
    assign read_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_master.sv
// Self-checking bench for axi_read_master: a randomizing AXI slave, a
// queue-based reference of expected AR addresses and read words, and a
// monitor that compares whatever the DUT presents against those queues.
module tb_axi_read_master;

    localparam logic [31:0] INC = 32'd4;
`ifdef AXI_READ_RESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] read_addr = 32'd0;
    logic [31:0] read_len = 32'd0;
    logic [31:0] read_data_out;
    logic        read_valid_out;
    logic        read_done_out;
    logic        read_err_out;
    logic [5:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;
    logic [5:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] slave_data[$];
    logic [1:0]  slave_resp[$];
    int          valid_cnt;
    int          ar_delay = 0;
    int          r_delay = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    int          r_owed = 0;
    bit          ar_hs = 1'b0;
    bit          r_hs = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_addr = 32'd0;

    always #5 clk = ~clk;

    axi_read_master dut (
        .m00_axi_aclk     (clk),
        .m00_axi_aresetn  (rst_n),
        .read_en_in       (read_en),
        .read_addr_in     (read_addr),
        .read_data_len_in (read_len),
        .read_data_out    (read_data_out),
        .read_valid_out   (read_valid_out),
        .read_done_out    (read_done_out),
        .read_err_out     (read_err_out),
        .m00_axi_arid     (arid),
        .m00_axi_araddr   (araddr),
        .m00_axi_arlen    (arlen),
        .m00_axi_arsize   (arsize),
        .m00_axi_arburst  (arburst),
        .m00_axi_arlock   (arlock),
        .m00_axi_arcache  (arcache),
        .m00_axi_arprot   (arprot),
        .m00_axi_arqos    (arqos),
        .m00_axi_arvalid  (arvalid),
        .m00_axi_arready  (arready),
        .m00_axi_rid      (rid),
        .m00_axi_rdata    (rdata),
        .m00_axi_rresp    (rresp),
        .m00_axi_rlast    (rlast),
        .m00_axi_rvalid   (rvalid),
        .m00_axi_rready   (rready)
    );

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // AXI slave: arready after ar_delay cycles of arvalid, then one R beat
    // ar_delay-independent r_delay cycles later, data taken from slave_data.
    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rid     = 6'd0;
        rlast   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                arready = 1'b0;
                rvalid  = 1'b0;
                r_owed  = 0;
                ar_cnt  = ar_delay;
                r_cnt   = r_delay;
            end else begin
                if (ar_hs) begin
                    arready = 1'b0;
                    ar_cnt  = ar_delay;
                    r_owed++;
                end else if (arvalid) begin
                    if (ar_cnt == 0) arready = 1'b1;
                    else ar_cnt--;
                end else begin
                    arready = 1'b0;
                end
                if (r_hs) begin
                    rvalid = 1'b0;
                    r_cnt  = r_delay;
                    rdata  = $urandom;
                end else if (!rvalid && r_owed > 0) begin
                    if (r_cnt == 0) begin
                        rvalid = 1'b1;
                        rdata  = (slave_data.size() > 0) ? slave_data.pop_front() : $urandom;
                        rresp  = (slave_resp.size() > 0) ? slave_resp.pop_front() : 2'b00;
                        rid    = 6'($urandom);
                        r_owed--;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: samples on the falling edge and compares against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ar_hs = 1'b0;
                r_hs  = 1'b0;
                held  = 1'b0;
            end else begin
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (arvalid && held) check_output("araddr_hold", araddr, held_addr);
                if (!arvalid) check_output("araddr_idle_zero", araddr, 32'd0);
                held = arvalid && !arready;
                held_addr = araddr;
                if (ar_hs) begin
                    check_output("ar_expected", 32'(exp_addr.size() > 0), 32'd1);
                    if (exp_addr.size() > 0) check_output("araddr", araddr, exp_addr.pop_front());
                    check_output("ar_fields",
                                 32'({arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid}),
                                 32'({4'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 6'd0}));
                end
                if (read_valid_out) begin
                    valid_cnt++;
                    check_output("beat_expected", 32'(exp_data.size() > 0), 32'd1);
                    if (exp_data.size() > 0) check_output("read_data", read_data_out, exp_data.pop_front());
                end
                if (read_done_out) check_output("done_after_last_beat", 32'(exp_data.size()), 32'd0);
            end
        end
    end

    task automatic flush_queues();
        exp_addr.delete();
        exp_data.delete();
        slave_data.delete();
        slave_resp.delete();
    endtask

    // One run: build the reference (address sequence, words, error flag),
    // start the DUT, wait for done and check run-level properties.
    task automatic apply_stimulus(input logic [31:0] addr, input int len, input int ard,
                                  input int rd, input int mode, input int bad, input bit poke);
        logic [31:0] a;
        logic [31:0] d;
        bit          exp_err;
        bit          got_done;
        int          cycles;
        a = addr;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(a);
            if (mode == 1) d = 32'hDEADBEEF;
            else if (mode == 2) d = 32'h11 * (i + 1);
            else d = $urandom;
            exp_data.push_back(d);
            slave_data.push_back(d);
            slave_resp.push_back((i == bad) ? 2'b10 : 2'b00);
            a = a + INC;
        end
        exp_err = ERR_EN && (bad >= 0) && (bad < len);
        ar_delay = ard;
        r_delay  = rd;
        ar_cnt   = ard;
        r_cnt    = rd;
        valid_cnt = 0;
        @(negedge clk);
        read_en   = 1'b1;
        read_addr = addr;
        read_len  = 32'(len);
        @(posedge clk);
        #1;
        read_en   = 1'b0;
        read_addr = $urandom;
        read_len  = $urandom;
        cycles    = 0;
        got_done  = read_done_out;
        while (!got_done && cycles < 200) begin
            read_en = poke && (cycles == 1);
            @(posedge clk);
            #1;
            cycles++;
            got_done = read_done_out;
        end
        read_en = 1'b0;
        check_output("done_seen", 32'(got_done), 32'd1);
        if (ard == 0 && rd == 0) check_output("run_cycles", 32'(cycles), 32'(2 * len));
        check_output("err_at_done", 32'(read_err_out), 32'(exp_err));
        @(posedge clk);
        #1;
        check_output("valid_pulses", 32'(valid_cnt), 32'(len));
        check_output("ar_all_issued", 32'(exp_addr.size()), 32'd0);
        check_output("done_one_cycle", 32'(read_done_out), 32'd0);
        check_output("err_sticky_idle", 32'(read_err_out), 32'(exp_err));
        if (!got_done) flush_queues();
    endtask

    initial begin
        int guard;
        #1;
        check_output("reset_arvalid", 32'(arvalid), 32'd0);
        check_output("reset_rready", 32'(rready), 32'd0);
        check_output("reset_outputs", {read_data_out[29:0], read_valid_out, read_done_out}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed runs");
        apply_stimulus(32'h0000_1000, 1, 0, 0, 1, -1, 1'b0);
        apply_stimulus(32'h0000_2000, 4, 0, 0, 2, -1, 1'b1);
        apply_stimulus(32'h0000_3000, 2, 3, 2, 0, -1, 1'b0);
        apply_stimulus(32'h0000_4000, 0, 0, 0, 0, -1, 1'b0);
        apply_stimulus(32'hFFFF_FFFC, 2, 0, 0, 0, -1, 1'b0);
        apply_stimulus(32'h0000_5000, 3, 1, 1, 0, 1, 1'b0);
        apply_stimulus(32'h0000_6000, 1, 0, 0, 1, -1, 1'b0);

        $display("[TB] rvalid while idle");
        rvalid = 1'b1;
        #1;
        check_output("idle_rready", 32'(rready), 32'd0);
        @(negedge clk);
        check_output("idle_no_valid", 32'(read_valid_out), 32'd0);
        rvalid = 1'b0;

        $display("[TB] reset during GET_DATA");
        apply_reset_mid_run: begin
            exp_addr.push_back(32'h0000_7000);
            ar_delay = 0;
            r_delay  = 8;
            ar_cnt   = 0;
            r_cnt    = 8;
            @(negedge clk);
            read_en   = 1'b1;
            read_addr = 32'h0000_7000;
            read_len  = 32'd2;
            @(negedge clk);
            read_en = 1'b0;
            guard = 0;
            while (!rready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check_output("reached_get_data", 32'(rready), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check_output("rst_arvalid", 32'(arvalid), 32'd0);
            check_output("rst_rready", 32'(rready), 32'd0);
            check_output("rst_data", read_data_out, 32'd0);
            check_output("rst_flags", 32'({read_valid_out, read_done_out, read_err_out}), 32'd0);
            flush_queues();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            apply_stimulus(32'h0000_8000, 3, 0, 0, 0, -1, 1'b0);
        end

        $display("[TB] random runs");
        for (int k = 0; k < 20; k++) begin
            apply_stimulus($urandom & 32'hFFFF_FFFC, $urandom_range(0, 5), $urandom_range(0, 3),
                           $urandom_range(0, 3), 0, $urandom_range(0, 7) - 1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
